alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/write-back controller and the initiator side of the register file and ALU. It accepts one register-register or register-immediate command per handshake. It then reads operands from the register file, drives the ALU, writes the result back to rd, and returns the result and flags on a response handshake. It sits between a command source (decoder or bench driver) and the existing RegisterFile/ALU pair. Those two blocks stay purely responders.

Parameters:
DATA_W, 32, datapath width of operands, immediate and result
SUPPRESS_WB_ON_OVF, 0, 1 = no register write when the ALU flags Overflow
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_alu_ctrl  input  4  ALU_Control code (0000 ADD, 0001 SUB, 1011 ADDI, others passed through)
cmd_rs1  input  5  source register 1
cmd_rs2  input  5  source register 2
cmd_rd  input  5  destination register
cmd_imm  input  DATA_W  immediate operand
cmd_use_imm  input  1  1 = ALU B operand is cmd_imm, otherwise readData2
rf_rs1  output  5  to RegisterFile rs1
rf_rs2  output  5  to RegisterFile rs2
rf_rdata1  input  DATA_W  from RegisterFile readData1 (combinational read)
rf_rdata2  input  DATA_W  from RegisterFile readData2
rf_rd  output  5  to RegisterFile rd
rf_wdata  output  DATA_W  to RegisterFile writeData
rf_we  output  1  to RegisterFile regWrite
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_ctrl  output  4  to ALU ALU_Control
alu_result  input  DATA_W  from ALU ALU_Result
alu_zero  input  1  from ALU Zero
alu_overflow  input  1  from ALU Overflow
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  DATA_W  captured ALU result
rsp_zero  output  1  captured Zero
rsp_overflow  output  1  captured Overflow
rsp_wrote  output  1  1 = this command performed a register write
done_count  output  CNT_W  number of completed responses, wraps to 0

Behaviour:
- FSM states: IDLE, READ, EXEC, WB, RESP. One clock; reset is asynchronous, active-high.
- Reset (any state, any cycle):
  - State goes to IDLE; all command and operand registers clear to 0.
  - Outputs: rf_we=0, rsp_valid=0, rsp_* = 0, done_count=0, cmd_ready=1, all address and data outputs 0.
  - No partial write: rf_we drops immediately on reset assertion.
- cmd_ready=1 only in IDLE.
- IDLE: on an edge with cmd_valid && cmd_ready, latch all cmd_* fields and go to READ. cmd_* is ignored in every other state.
- READ: rf_rs1/rf_rs2 are driven from the latched addresses. At the edge, capture opA=rf_rdata1 and opB=(use_imm ? imm : rf_rdata2), then go to EXEC.
- EXEC: alu_a=opA, alu_b=opB, alu_ctrl=latched code. These are held stable for the whole state and are 0 outside EXEC. At the edge, capture alu_result/zero/overflow, then go to WB.
- WB: rf_rd=latched rd and rf_wdata=captured result.
  - rf_we=1 for exactly this one cycle, unless rd==0 or (SUPPRESS_WB_ON_OVF && overflow).
  - rsp_wrote records whether the write happened.
  - Go to RESP.
- RESP: rsp_valid=1 and rsp_* held constant until rsp_ready is sampled high.
  - On that edge: rsp_valid drops, done_count increments (wrapping modulo 2^CNT_W), state goes to IDLE.
- Latency: accept edge N -> rf_we high during cycle N+2..N+3 -> rsp_valid high from edge N+3. Minimum issue interval is 5 cycles when rsp_ready is tied high.
- Back-to-back: a new command is accepted only on the edge after response completion. No overlap with a pending response.
- rd == rs1 or rd == rs2 needs no special handling, because operands are captured before WB.
- The controller does no flag interpretation; Zero/Overflow are forwarded exactly as captured.

Test Plan:
- Regfile preloaded x1=10, x2=5; cmd ADD rs1=1 rs2=2 rd=3 -> rf_we pulses one cycle with wdata=15; rsp_result=15, zero=0, overflow=0, rsp_wrote=1; read-back x3=15.
- SUB rs1=1 rs2=2 rd=4 -> rsp_result=5. Then SUB rs1=1 rs2=1 rd=5 -> rsp_result=0, rsp_zero=1.
- ADDI (1011) rs1=1 imm=20 use_imm=1 rd=6 -> rsp_result=30, x6=30; rf_rdata2 value is ignored.
- ADD with x7=0x7FFFFFFF, x8=1, rd=9 -> overflow=1. With SUPPRESS_WB_ON_OVF=0: x9=0x80000000, rsp_wrote=1. With =1: no rf_we, rsp_wrote=0. Separately, rd=0 -> no rf_we.
- rsp_ready held low 3 cycles in RESP -> rsp_valid and data stable, cmd_ready=0, done_count unchanged; then rsp_ready=1 -> done_count+1 and cmd_ready=1 next cycle.
- Assert reset during EXEC -> rf_we never pulses, rsp_valid=0, cmd_ready=1 immediately, destination register unchanged; a following ADD completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/write-back controller: fetches operands from the register file,
// drives the ALU, writes the result back to rd and returns result/flags on a response.
module alu_issue_ctrl #(
   parameter int DATA_W             = 32,
   parameter bit SUPPRESS_WB_ON_OVF = 1'b0,
   parameter int CNT_W              = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_alu_ctrl,
   input  logic [4:0]        cmd_rs1,
   input  logic [4:0]        cmd_rs2,
   input  logic [4:0]        cmd_rd,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              cmd_use_imm,
   output logic [4:0]        rf_rs1,
   output logic [4:0]        rf_rs2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic [4:0]        rf_rd,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic              rsp_wrote,
   output logic [CNT_W-1:0]  done_count,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [3:0]          ctrl_q;
   logic [4:0]          rs1_q;
   logic [4:0]          rs2_q;
   logic [4:0]          rd_q;
   logic [DATA_W-1:0]   imm_q;
   logic                use_imm_q;
   logic [DATA_W-1:0]   op_a_q;
   logic [DATA_W-1:0]   op_b_q;
   logic [DATA_W-1:0]   res_q;
   logic                zero_q;
   logic                ovf_q;
   logic                wrote_q;
   logic [CNT_W-1:0]    done_q;

   logic                cmd_fire;
   logic                rsp_fire;
   logic                wb_en;

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
   // cmd_ready and rsp_valid are pure functions of state, never of the partner's signal.
   assign cmd_fire = (state_q == IDLE) && cmd_valid;
   assign rsp_fire = (state_q == RESP) && rsp_ready;

   // x0 is never written; optionally an overflowing result is dropped too.
   assign wb_en = (rd_q != 5'd0) && !(SUPPRESS_WB_ON_OVF && ovf_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_fire) state_d = READ;
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = RESP;
         RESP:    if (rsp_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q    <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wrote_q   <= 1'b0;
         done_q    <= '0;
      end else begin
         if (cmd_fire) begin
            ctrl_q    <= cmd_alu_ctrl;
            rs1_q     <= cmd_rs1;
            rs2_q     <= cmd_rs2;
            rd_q      <= cmd_rd;
            imm_q     <= cmd_imm;
            use_imm_q <= cmd_use_imm;
         end
         // Operands are frozen here, so rd aliasing rs1/rs2 is harmless at write-back.
         if (state_q == READ) begin
            op_a_q <= rf_rdata1;
            op_b_q <= use_imm_q ? imm_q : rf_rdata2;
         end
         if (state_q == EXEC) begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
            ovf_q  <= alu_overflow;
         end
         if (state_q == WB) begin
            wrote_q <= wb_en;
         end
         if (rsp_fire) begin
            done_q <= done_q + CNT_W'(1);
         end
      end
   end

   // Every interface output is zero outside the state that owns it.
   always_comb begin
      cmd_ready    = 1'b0;
      rf_rs1       = '0;
      rf_rs2       = '0;
      rf_rd        = '0;
      rf_wdata     = '0;
      rf_we        = 1'b0;
      alu_a        = '0;
      alu_b        = '0;
      alu_ctrl     = '0;
      rsp_valid    = 1'b0;
      rsp_result   = '0;
      rsp_zero     = 1'b0;
      rsp_overflow = 1'b0;
      rsp_wrote    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         READ: begin
            rf_rs1 = rs1_q;
            rf_rs2 = rs2_q;
         end
         EXEC: begin
            alu_a    = op_a_q;
            alu_b    = op_b_q;
            alu_ctrl = ctrl_q;
         end
         WB: begin
            rf_rd    = rd_q;
            rf_wdata = res_q;
            rf_we    = wb_en;
         end
         RESP: begin
            rsp_valid    = 1'b1;
            rsp_result   = res_q;
            rsp_zero     = zero_q;
            rsp_overflow = ovf_q;
            rsp_wrote    = wrote_q;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   assign done_count = done_q;
   assign dbg_state  = state_q;

endmodule
